// File: rtl/foc_pkg.sv
// Shared definitions for the FOC bus-voltage scaling / PWM-gain stage.
//   foc_state_e    : top-level FSM states
//   KPWM_NUM       : default gain dividend
//   VBUS_SCALE_Q12 : default bus-voltage scale (about 12.4617 in Q.12)
package foc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScale,
    StDiv,
    StDone
  } foc_state_e;

  localparam int unsigned KPWM_NUM       = 420;
  localparam int unsigned VBUS_SCALE_Q12 = 51043;

endpackage

// File: rtl/foc_vbus_kpwm_div_if.sv
// Request/result bundle of the bus-voltage scaling / PWM-gain stage.
//   Request : in_valid, in_ready, in_ch, voltage
//   Result  : out_valid (one-cycle strobe), out_ch, voltage_o, k_pwm_o, sat_o, div0_o
// master = requester and result consumer, slave = the computing block.
interface foc_vbus_kpwm_div_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned CH_W = 2
) ();

  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [DW-1:0]   voltage;

  logic            out_valid;
  logic [CH_W-1:0] out_ch;
  logic [DW-1:0]   voltage_o;
  logic [DW-1:0]   k_pwm_o;
  logic            sat_o;
  logic            div0_o;

  modport master (
    output in_valid, in_ch, voltage,
    input  in_ready, out_valid, out_ch, voltage_o, k_pwm_o, sat_o, div0_o
  );

  modport slave (
    input  in_valid, in_ch, voltage,
    output in_ready, out_valid, out_ch, voltage_o, k_pwm_o, sat_o, div0_o
  );

endinterface

// File: rtl/foc_udiv_seq.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor when idle; ignored while busy
//   dividend  : W-bit dividend
//   divisor   : W-bit divisor, must be non-zero
//   busy      : operation in progress (W cycles)
//   done      : high on the cycle of the final step; quotient/remainder are
//               valid from the following cycle until the next start
//   quotient  : W-bit quotient
//   remainder : W-bit remainder
module foc_udiv_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    dq_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [W-1:0]    rem_q;
  logic [W-1:0]    dvs_q;

  logic [W:0]      rem_sh;
  logic [W:0]      rem_sub;
  logic            q_bit;
  logic [W-1:0]    rem_nx;

  always_comb begin
    rem_sh  = {rem_q, dq_q[W-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    // rem_sh < 2*divisor, so a clear top bit of the difference means rem_sh >= divisor
    q_bit   = ~rem_sub[W];
    rem_nx  = q_bit ? rem_sub[W-1:0] : rem_sh[W-1:0];
  end

  assign done      = busy_q && (cnt_q == CntW'(W - 1));
  assign busy      = busy_q;
  assign quotient  = dq_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dq_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (busy_q) begin
      dq_q  <= {dq_q[W-2:0], q_bit};
      rem_q <= rem_nx;
      cnt_q <= cnt_q + CntW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      dq_q   <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end
  end

endmodule

// File: rtl/foc_vbus_kpwm_div.sv
// Bus-voltage scaling and PWM-gain stage.
// Scales a raw voltage by SCALE (Q.SCALE_FRAC, saturating to DW bits), then
// computes k = K_NUM / v_scaled with a sequential divider. A zero scaled
// voltage bypasses the divider and forces k to all-ones.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of the request/result bundle
//         in_valid/in_ready/in_ch/voltage in, out_valid/out_ch/voltage_o/
//         k_pwm_o/sat_o/div0_o out (outputs hold until the next result)
module foc_vbus_kpwm_div import foc_pkg::*; #(
  parameter int unsigned DW         = 32,
  parameter int unsigned SCALE      = VBUS_SCALE_Q12,
  parameter int unsigned SCALE_W    = 16,
  parameter int unsigned SCALE_FRAC = 12,
  parameter int unsigned K_NUM      = KPWM_NUM,
  parameter int unsigned CH_W       = 2
) (
  input logic                clk,
  input logic                rst,
  foc_vbus_kpwm_div_if.slave bus
);

  localparam int unsigned PW = DW + SCALE_W;

  foc_state_e      state_q;
  logic [DW-1:0]   volt_q;
  logic [CH_W-1:0] ch_q;
  logic [DW-1:0]   vsc_q;
  logic            sat_q;
  logic            div0_q;

  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic [DW-1:0]   voltage_q;
  logic [DW-1:0]   k_pwm_q;
  logic            sat_out_q;
  logic            div0_out_q;

  logic [PW-1:0]   prod;
  logic [PW-1:0]   prod_sh;
  logic            sat_c;
  logic [DW-1:0]   vsc_c;

  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic [DW-1:0]   div_quot;
  logic [DW-1:0]   div_rem;

  always_comb begin
    prod    = PW'(volt_q) * PW'(SCALE);
    prod_sh = prod >> SCALE_FRAC;
    sat_c   = |prod_sh[PW-1:DW];
    vsc_c   = sat_c ? '1 : prod_sh[DW-1:0];
  end

  // Divider is loaded at the end of the scale cycle so it starts stepping with DIV.
  assign div_start = (state_q == StScale) && (vsc_c != '0);

  foc_udiv_seq #(
    .W (DW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (DW'(K_NUM)),
    .divisor   (vsc_c),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      volt_q      <= '0;
      ch_q        <= '0;
      vsc_q       <= '0;
      sat_q       <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      voltage_q   <= '0;
      k_pwm_q     <= '0;
      sat_out_q   <= 1'b0;
      div0_out_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            volt_q  <= bus.voltage;
            ch_q    <= bus.in_ch;
            state_q <= StScale;
          end
        end
        StScale: begin
          vsc_q <= vsc_c;
          sat_q <= sat_c;
          if (vsc_c == '0) begin
            div0_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            div0_q  <= 1'b0;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          voltage_q   <= vsc_q;
          k_pwm_q     <= div0_q ? '1 : div_quot;
          sat_out_q   <= sat_q;
          div0_out_q  <= div0_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // rst gates in_ready combinationally so a request coinciding with reset is never taken.
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.voltage_o = voltage_q;
  assign bus.k_pwm_o   = k_pwm_q;
  assign bus.sat_o     = sat_out_q;
  assign bus.div0_o    = div0_out_q;

  a_div_busy: assert property (@(posedge clk) disable iff (rst)
    (state_q == StDiv) |-> div_busy);

  a_rem_lt_divisor: assert property (@(posedge clk) disable iff (rst)
    ((state_q == StDone) && !div0_q) |-> (div_rem < vsc_q));

endmodule
